rob_multi_cdb: RTL and testbench

- Parametrised reorder buffer. Successor of the single-CDB ROB.
- Allocates entries in program order from the decoder and accepts results from NUM_CDB broadcast channels (ALU, branch, LSBuf).
- Retires one ready head entry per cycle: normal ops write the regfile, stores release the LS buffer, mispredicted branches flush the whole window.
- Sits between decoder/PC (allocation, operand tag lookup) and regfile/LSBuf (commit).

---
 rtl/rob_multi_cdb.sv | 184 ++++++++++++++++++
 tb/tb_rob_multi_cdb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi_cdb.sv
// Reorder buffer with several result broadcast channels.
// In-order allocate, out-of-order complete, in-order retire with branch flush.
module rob_multi_cdb #(
    parameter int IDX_W   = 4,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int NUM_CDB = 3,
    localparam int DEPTH  = 2**IDX_W,
    localparam int TAG_W  = IDX_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ins_valid,
    input  logic [1:0]                  ins_class,
    input  logic [REG_W-1:0]            ins_rd,
    output logic                        ins_ready,
    output logic [TAG_W-1:0]            ins_tag,
    input  logic [3*TAG_W-1:0]          chk_tag,
    output logic [2:0]                  chk_ready,
    output logic [3*DATA_W-1:0]         chk_data,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    input  logic [NUM_CDB-1:0]          cdb_mispredict,
    output logic                        commit_reg_en,
    output logic [REG_W-1:0]            commit_reg_name,
    output logic [DATA_W-1:0]           commit_reg_data,
    output logic [TAG_W-1:0]            commit_reg_tag,
    output logic                        commit_store,
    output logic                        flush_valid,
    output logic [DATA_W-1:0]           flush_pc,
    output logic [IDX_W:0]              count
);

    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_BR   = 2'd1;
    localparam logic [1:0] CLS_ST   = 2'd2;
    localparam logic [1:0] CLS_NOP  = 2'd3;

    logic              e_valid [DEPTH];
    logic              e_ready [DEPTH];
    logic              e_mis   [DEPTH];
    logic [1:0]        e_cls   [DEPTH];
    logic [REG_W-1:0]  e_rd    [DEPTH];
    logic [DATA_W-1:0] e_data  [DEPTH];

    logic [IDX_W-1:0]  front;
    logic [IDX_W-1:0]  tail;

    logic              wr_en   [DEPTH];
    logic              wr_mis  [DEPTH];
    logic [DATA_W-1:0] wr_data [DEPTH];

    logic commit_ok;
    logic do_flush;
    logic alloc;

    assign ins_ready = (count != (IDX_W+1)'(DEPTH));
    assign ins_tag   = {1'b0, tail};
    assign commit_ok = (count != '0) && e_valid[front] && e_ready[front];
    assign do_flush  = commit_ok && (e_cls[front] == CLS_BR) && e_mis[front];
    assign alloc     = ins_valid && ins_ready && !do_flush;

    // Per-entry CDB capture; descending scan lets the lowest channel win.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wr_en[i]   = 1'b0;
            wr_mis[i]  = 1'b0;
            wr_data[i] = '0;
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (cdb_valid[c] && !cdb_tag[c*TAG_W + IDX_W]
                    && cdb_tag[c*TAG_W +: IDX_W] == IDX_W'(i)
                    && e_valid[i]) begin
                    wr_en[i]   = 1'b1;
                    wr_mis[i]  = cdb_mispredict[c];
                    wr_data[i] = cdb_data[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Operand lookup with same-cycle CDB bypass.
    always_comb begin : lookup
        logic [TAG_W-1:0] t;
        t         = '0;
        chk_ready = '0;
        chk_data  = '0;
        for (int p = 0; p < 3; p++) begin
            t = chk_tag[p*TAG_W +: TAG_W];
            if (t[IDX_W]) begin
                chk_ready[p] = 1'b1;
            end else begin
                chk_ready[p] = e_ready[t[IDX_W-1:0]];
                chk_data[p*DATA_W +: DATA_W] = e_data[t[IDX_W-1:0]];
                for (int c = NUM_CDB - 1; c >= 0; c--) begin
                    if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
                        chk_ready[p] = 1'b1;
                        chk_data[p*DATA_W +: DATA_W] =
                            cdb_data[c*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Window state, retire and allocation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_valid[i] <= 1'b0;
                e_ready[i] <= 1'b0;
                e_mis[i]   <= 1'b0;
                e_cls[i]   <= CLS_NORM;
                e_rd[i]    <= '0;
                e_data[i]  <= '0;
            end
            front           <= '0;
            tail            <= '0;
            count           <= '0;
            commit_reg_en   <= 1'b0;
            commit_reg_name <= '0;
            commit_reg_data <= '0;
            commit_reg_tag  <= '0;
            commit_store    <= 1'b0;
            flush_valid     <= 1'b0;
            flush_pc        <= '0;
        end else begin
            commit_reg_en <= 1'b0;
            commit_store  <= 1'b0;
            flush_valid   <= 1'b0;
            if (do_flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    e_valid[i] <= 1'b0;
                    e_ready[i] <= 1'b0;
                    e_mis[i]   <= 1'b0;
                end
                front       <= '0;
                tail        <= '0;
                count       <= '0;
                flush_valid <= 1'b1;
                flush_pc    <= e_data[front];
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_en[i]) begin
                        e_ready[i] <= 1'b1;
                        e_mis[i]   <= wr_mis[i];
                        e_data[i]  <= wr_data[i];
                    end
                end
                if (commit_ok) begin
                    e_valid[front] <= 1'b0;
                    e_ready[front] <= 1'b0;
                    e_mis[front]   <= 1'b0;
                    front          <= front + IDX_W'(1);
                    unique case (e_cls[front])
                        CLS_NORM: begin
                            commit_reg_en   <= 1'b1;
                            commit_reg_name <= e_rd[front];
                            commit_reg_data <= e_data[front];
                            commit_reg_tag  <= {1'b0, front};
                        end
                        CLS_ST:  commit_store <= 1'b1;
                        CLS_BR:  ;
                        CLS_NOP: ;
                    endcase
                end
                if (alloc) begin
                    e_valid[tail] <= 1'b1;
                    e_ready[tail] <= (ins_class == CLS_NOP);
                    e_mis[tail]   <= 1'b0;
                    e_cls[tail]   <= ins_class;
                    e_rd[tail]    <= ins_rd;
                    e_data[tail]  <= '0;
                    tail          <= tail + IDX_W'(1);
                end
                if (alloc && !commit_ok)
                    count <= count + (IDX_W+1)'(1);
                else if (commit_ok && !alloc)
                    count <= count - (IDX_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_cdb.sv
// Directed bench for rob_multi_cdb.
// Allocation, CDB capture/bypass, retire, flush and reset.
module tb_rob_multi_cdb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_valid;
    logic [1:0]  ins_class;
    logic [4:0]  ins_rd;
    logic        ins_ready;
    logic [4:0]  ins_tag;
    logic [14:0] chk_tag;
    logic [2:0]  chk_ready;
    logic [95:0] chk_data;
    logic [2:0]  cdb_valid;
    logic [14:0] cdb_tag;
    logic [95:0] cdb_data;
    logic [2:0]  cdb_mispredict;
    logic        commit_reg_en;
    logic [4:0]  commit_reg_name;
    logic [31:0] commit_reg_data;
    logic [4:0]  commit_reg_tag;
    logic        commit_store;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic [4:0]  count;

    int passed = 0;
    int total  = 0;

    rob_multi_cdb dut (
        .clk             (clk),
        .rst             (rst),
        .ins_valid       (ins_valid),
        .ins_class       (ins_class),
        .ins_rd          (ins_rd),
        .ins_ready       (ins_ready),
        .ins_tag         (ins_tag),
        .chk_tag         (chk_tag),
        .chk_ready       (chk_ready),
        .chk_data        (chk_data),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .cdb_mispredict  (cdb_mispredict),
        .commit_reg_en   (commit_reg_en),
        .commit_reg_name (commit_reg_name),
        .commit_reg_data (commit_reg_data),
        .commit_reg_tag  (commit_reg_tag),
        .commit_store    (commit_store),
        .flush_valid     (flush_valid),
        .flush_pc        (flush_pc),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    endtask

    task automatic set_cdb(input int ch, input logic [4:0] t,
                           input logic [31:0] d, input logic m);
        cdb_valid[ch]         = 1'b1;
        cdb_tag[ch*5 +: 5]    = t;
        cdb_data[ch*32 +: 32] = d;
        cdb_mispredict[ch]    = m;
    endtask

    task automatic clr_cdb();
        cdb_valid      = '0;
        cdb_tag        = '0;
        cdb_data       = '0;
        cdb_mispredict = '0;
    endtask

    task automatic alloc(input logic [1:0] cls, input logic [4:0] rd);
        ins_valid = 1'b1;
        ins_class = cls;
        ins_rd    = rd;
        tick();
        ins_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        ins_valid = 1'b0;
        ins_class = 2'd0;
        ins_rd = '0;
        chk_tag = {5'h10, 5'h10, 5'h10};
        clr_cdb();
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(ins_ready), 64'd1);
        chk("rst_tag", 64'(ins_tag), 64'd0);
        chk("rst_pulses", 64'({commit_reg_en, commit_store, flush_valid}),
            64'd0);
        rst = 1'b1;
        tick();

        // three normal ops, out-of-order completion
        alloc(2'd0, 5'd1);
        alloc(2'd0, 5'd2);
        alloc(2'd0, 5'd3);
        chk("a_count3", 64'(count), 64'd3);
        set_cdb(0, 5'd1, 32'hAA, 1'b0);
        tick();
        set_cdb(0, 5'd0, 32'h55, 1'b0);
        tick();
        clr_cdb();
        chk("a_no_commit_yet", 64'(commit_reg_en), 64'd0);
        tick();
        chk("a_c0", 64'({commit_reg_en, commit_reg_name, commit_reg_tag}),
            64'({1'b1, 5'd1, 5'd0}));
        chk("a_c0_data", 64'(commit_reg_data), 64'h55);
        chk("a_count2", 64'(count), 64'd2);
        tick();
        chk("a_c1", 64'({commit_reg_en, commit_reg_name, commit_reg_tag}),
            64'({1'b1, 5'd2, 5'd1}));
        chk("a_c1_data", 64'(commit_reg_data), 64'hAA);
        tick();
        chk("a_idle", 64'(commit_reg_en), 64'd0);
        chk("a_count1", 64'(count), 64'd1);

        // fill the window completely
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ins_valid = 1'b1;
            ins_class = 2'd0;
            ins_rd    = 5'(i);
            tick();
        end
        ins_valid = 1'b0;
        chk("b_full_count", 64'(count), 64'd16);
        chk("b_full_ready", 64'(ins_ready), 64'd0);
        chk("b_tag_wrap", 64'(ins_tag), 64'd0);
        set_cdb(0, 5'd0, 32'h100, 1'b0);
        tick();
        clr_cdb();
        ins_valid = 1'b1;
        ins_class = 2'd0;
        ins_rd    = 5'd7;
        tick();
        chk("b_retire_count", 64'(count), 64'd15);
        chk("b_retire_en", 64'(commit_reg_en), 64'd1);
        chk("b_retire_data", 64'(commit_reg_data), 64'h100);
        chk("b_no_alloc_tag", 64'(ins_tag), 64'd0);
        tick();
        ins_valid = 1'b0;
        chk("b_alloc_count", 64'(count), 64'd16);
        chk("b_alloc_tag", 64'(ins_tag), 64'd1);

        // bypass and free-tag lookups
        chk_tag = {5'd6, 5'h10, 5'd5};
        set_cdb(1, 5'd5, 32'h10, 1'b0);
        #1;
        chk("c_byp_ready", 64'(chk_ready), 64'b011);
        chk("c_byp_data", 64'(chk_data[31:0]), 64'h10);
        chk("c_free_data", 64'(chk_data[63:32]), 64'd0);
        tick();
        clr_cdb();
        #1;
        chk("c_entry_ready", 64'(chk_ready[0]), 64'd1);
        chk("c_entry_data", 64'(chk_data[31:0]), 64'h10);

        // duplicate tag on one edge: channel 0 wins
        set_cdb(0, 5'd3, 32'h1, 1'b0);
        set_cdb(2, 5'd3, 32'h2, 1'b0);
        tick();
        clr_cdb();
        chk_tag = {5'h10, 5'h10, 5'd3};
        #1;
        chk("d_dup_ready", 64'(chk_ready[0]), 64'd1);
        chk("d_dup_data", 64'(chk_data[31:0]), 64'h1);

        // mispredicted branch flushes the window
        do_reset();
        alloc(2'd1, 5'd0);
        for (int i = 0; i < 4; i++) alloc(2'd0, 5'(i + 4));
        chk("e_count5", 64'(count), 64'd5);
        set_cdb(1, 5'd0, 32'h400, 1'b1);
        tick();
        clr_cdb();
        ins_valid = 1'b1;
        ins_class = 2'd0;
        ins_rd    = 5'd9;
        tick();
        ins_valid = 1'b0;
        chk("e_flush", 64'({flush_valid, commit_reg_en}), 64'b10);
        chk("e_flush_pc", 64'(flush_pc), 64'h400);
        chk("e_count0", 64'(count), 64'd0);
        chk("e_tag0", 64'(ins_tag), 64'd0);
        chk_tag = {5'h10, 5'h10, 5'd1};
        tick();
        chk("e_pulse_end", 64'({flush_valid, commit_reg_en}), 64'd0);
        chk("e_young_gone", 64'(chk_ready[0]), 64'd0);
        chk("e_count_stay", 64'(count), 64'd0);

        // store commit and nop retire
        alloc(2'd2, 5'd0);
        set_cdb(2, 5'd0, 32'h77, 1'b0);
        tick();
        clr_cdb();
        tick();
        chk("f_store", 64'({commit_store, commit_reg_en}), 64'b10);
        chk("f_store_count", 64'(count), 64'd0);
        tick();
        chk("f_store_end", 64'(commit_store), 64'd0);
        alloc(2'd3, 5'd4);
        chk("f_nop_count", 64'(count), 64'd1);
        tick();
        chk("f_nop_retire", 64'({count, commit_reg_en, commit_store}),
            64'd0);

        // asynchronous reset mid-stream
        alloc(2'd0, 5'd8);
        alloc(2'd0, 5'd9);
        set_cdb(0, 5'd2, 32'h99, 1'b0);
        tick();
        clr_cdb();
        chk("g_pre_count", 64'(count), 64'd2);
        rst = 1'b0;
        #2;
        chk("g_rst_count", 64'(count), 64'd0);
        chk("g_rst_outs", 64'({commit_reg_en, commit_store, flush_valid,
            commit_reg_name, commit_reg_tag}), 64'd0);
        chk("g_rst_data", 64'({commit_reg_data, flush_pc}), 64'd0);
        chk("g_rst_tag", 64'(ins_tag), 64'd0);
        rst = 1'b1;
        tick();
        chk("g_no_commit", 64'({commit_reg_en, count}), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
